// File: rtl/sigmoid_backward.sv
// ============================================================================
// sigmoid_backward : serial input-gradient g*y*(1-y) over a saved sigmoid vector
// Revision 1.0
// ============================================================================
`default_nettype none

module sigmoid_backward #(
  parameter int WIDTH      = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [WIDTH*DATA_WIDTH-1:0]   act_vector,
  input  logic [WIDTH*DATA_WIDTH-1:0]   grad_vector,
  output logic [WIDTH*DATA_WIDTH-1:0]   output_vector,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W   = $clog2(WIDTH + 1);
  localparam int SEL_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW      = 2 * DATA_WIDTH;
  localparam int ONE_INT = 1 << FRAC_BITS;
  localparam logic signed [DATA_WIDTH-1:0] C_ONE   = DATA_WIDTH'(ONE_INT);
  localparam logic signed [PW-1:0]         C_ONE_W = PW'(ONE_INT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          state_q;
  logic [IDX_W-1:0]                idx_q;
  logic                            s1_valid_q;
  logic signed [DATA_WIDTH-1:0]    s1_d_q;
  logic signed [DATA_WIDTH-1:0]    s1_g_q;
  logic [SEL_W-1:0]                s1_idx_q;
  logic [WIDTH*DATA_WIDTH-1:0]     out_q;
  logic                            busy_q;
  logic                            done_q;

  logic [SEL_W-1:0]                w_sel;
  logic signed [DATA_WIDTH-1:0]    w_y;
  logic signed [DATA_WIDTH-1:0]    w_g;
  logic signed [DATA_WIDTH-1:0]    w_yc;
  logic signed [PW-1:0]            w_yc_ext;
  logic signed [PW-1:0]            w_dprod;
  logic signed [DATA_WIDTH-1:0]    w_d;
  logic signed [PW-1:0]            w_g_ext;
  logic signed [PW-1:0]            w_d_ext;
  logic signed [PW-1:0]            w_p;
  logic [DATA_WIDTH-1:0]           w_out;
  logic                            w_issue;
  logic                            w_last;

  // Stage 1: clamp y into [0, ONE] and form the local derivative d.
  always_comb begin
    w_sel = idx_q[SEL_W-1:0];
    w_y   = act_vector[w_sel*DATA_WIDTH +: DATA_WIDTH];
    w_g   = grad_vector[w_sel*DATA_WIDTH +: DATA_WIDTH];
    if (w_y < 0)
      w_yc = '0;
    else if (w_y > C_ONE)
      w_yc = C_ONE;
    else
      w_yc = w_y;
    w_yc_ext = {{DATA_WIDTH{1'b0}}, w_yc};
    w_dprod  = w_yc_ext * (C_ONE_W - w_yc_ext);
    w_d      = DATA_WIDTH'(w_dprod >>> FRAC_BITS);
  end

  // Stage 2: d <= ONE/4, so the scaled product always fits without saturation.
  always_comb begin
    w_g_ext = {{DATA_WIDTH{s1_g_q[DATA_WIDTH-1]}}, s1_g_q};
    w_d_ext = {{DATA_WIDTH{1'b0}}, s1_d_q};
    w_p     = w_g_ext * w_d_ext;
    w_out   = DATA_WIDTH'(w_p >>> FRAC_BITS);
    w_issue = (idx_q < IDX_W'(WIDTH));
    w_last  = s1_valid_q && (s1_idx_q == SEL_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_d_q     <= '0;
      s1_g_q     <= '0;
      s1_idx_q   <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // An element already in stage 1 always lands, even on an aborting edge.
      if (s1_valid_q)
        out_q[s1_idx_q*DATA_WIDTH +: DATA_WIDTH] <= w_out;
      case (state_q)
        S_IDLE: begin
          s1_valid_q <= 1'b0;
          done_q     <= 1'b0;
          if (enable) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable) begin
            state_q    <= S_IDLE;
            s1_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
          end else begin
            s1_valid_q <= w_issue;
            if (w_issue) begin
              s1_d_q   <= w_d;
              s1_g_q   <= w_g;
              s1_idx_q <= w_sel;
              idx_q    <= idx_q + 1'b1;
            end
            if (w_last) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          s1_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          if (!enable) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          s1_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign output_vector = out_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_backward.sv
// ============================================================================
// tb_sigmoid_backward : directed and randomized checks against a reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sigmoid_backward;

  localparam int W  = 128;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int ONE = 1 << FB;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [W*DW-1:0]   act_v;
  logic [W*DW-1:0]   grad_v;
  logic [W*DW-1:0]   out_v;
  logic              busy;
  logic              done;

  logic [DW-1:0]     exp_q [W];
  int                pass_cnt;
  int                total_cnt;
  int                fail_cnt;

  sigmoid_backward #(.WIDTH(W), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .act_vector   (act_v),
    .grad_vector  (grad_v),
    .output_vector(out_v),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] y, input logic [DW-1:0] g);
    int yi, gi, yc, d, p;
    logic [31:0] pv;
    yi = int'($signed(y));
    gi = int'($signed(g));
    yc = (yi < 0) ? 0 : ((yi > ONE) ? ONE : yi);
    d  = (yc * (ONE - yc)) / ONE;
    p  = (gi * d) >>> FB;
    pv = p;
    return pv[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [W*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic chk_vec(input string tag);
    for (int i = 0; i < W; i++)
      chk($sformatf("%s[%0d]", tag, i), {16'h0, elem(out_v, i)}, {16'h0, exp_q[i]});
  endtask

  task automatic fill_const(input logic [DW-1:0] y, input logic [DW-1:0] g);
    for (int i = 0; i < W; i++) begin
      act_v[i*DW +: DW]  = y;
      grad_v[i*DW +: DW] = g;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < W; i++) begin
      logic [DW-1:0] y;
      if ($urandom_range(7) == 0) y = DW'($urandom);
      else                        y = DW'($urandom_range(16'h0140));
      act_v[i*DW +: DW]  = y;
      grad_v[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic model_upto(input int n);
    for (int i = 0; i < n; i++)
      exp_q[i] = model(elem(act_v, i), elem(grad_v, i));
  endtask

  // Full run: start from IDLE, measure edges to done, then release enable.
  task automatic full_run(input string tag);
    int n;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_after_start"}, {31'h0, busy}, 32'h1);
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    model_upto(W);
    chk_vec(tag);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_held"}, {31'h0, done}, 32'h1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_cleared"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
    reset = 1'b1; enable = 1'b0;
    act_v = '0; grad_v = '0;
    for (int i = 0; i < W; i++) exp_q[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk_vec("reset_out");
    @(negedge clk);
    reset = 1'b0;

    fill_const(16'h0080, 16'h0100);
    full_run("center");
    chk("center_e5_const", {16'h0, elem(out_v, 5)}, 32'h0040);

    fill_const(16'h00C0, 16'hFE00);
    full_run("neggrad");
    chk("neggrad_const", {16'h0, elem(out_v, 77)}, 32'hFFA0);

    for (int i = 0; i < W; i++) begin
      case (i % 4)
        0: act_v[i*DW +: DW] = 16'h0000;
        1: act_v[i*DW +: DW] = 16'h0100;
        2: act_v[i*DW +: DW] = 16'h0180;
        default: act_v[i*DW +: DW] = 16'hFF00;
      endcase
      grad_v[i*DW +: DW] = 16'h0100;
    end
    full_run("clamp");
    chk("clamp_neg_const", {16'h0, elem(out_v, 3)}, 32'h0000);

    for (int i = 0; i < W; i++) begin
      case (i % 3)
        0: begin act_v[i*DW +: DW] = 16'h0080; grad_v[i*DW +: DW] = 16'hFFFF; end
        1: begin act_v[i*DW +: DW] = 16'h0080; grad_v[i*DW +: DW] = 16'h7FFF; end
        default: begin act_v[i*DW +: DW] = 16'h0001; grad_v[i*DW +: DW] = 16'h7FFF; end
      endcase
    end
    full_run("extreme");
    chk("floor_const", {16'h0, elem(out_v, 0)}, 32'hFFFF);
    chk("max_const",   {16'h0, elem(out_v, 1)}, 32'h1FFF);
    chk("dzero_const", {16'h0, elem(out_v, 2)}, 32'h0000);

    // Back-to-back random runs with a single IDLE cycle between them.
    fill_rand();
    full_run("rand_a");
    fill_rand();
    full_run("rand_b");

    // Abort: enable low at E9 lands element 7 and flushes the rest.
    fill_rand();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_done", {31'h0, done}, 32'h0);
    model_upto(8);
    chk_vec("abort");

    // Enable dropped on the last-write edge: all written, done never seen.
    fill_rand();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    repeat (W) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("lastdrop_done", {31'h0, done}, 32'h0);
    chk("lastdrop_busy", {31'h0, busy}, 32'h0);
    model_upto(W);
    chk_vec("lastdrop");

    // Asynchronous reset mid-run, checked before the next clock edge.
    fill_rand();
    @(negedge clk);
    enable = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_busy", {31'h0, busy}, 32'h0);
    chk("areset_done", {31'h0, done}, 32'h0);
    for (int i = 0; i < W; i++) exp_q[i] = '0;
    chk_vec("areset");
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    fill_rand();
    full_run("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sigmoid_backward.md
# sigmoid_backward

Backward-pass companion to the `sigmoid` activation block. It takes the sigmoid outputs `y` saved from the forward pass and an upstream gradient vector `g`, then computes the input gradient `g * y * (1 - y)` for every element. Elements are processed serially through a 2-stage multiply pipeline. The block uses the same Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS two's-complement format and the same `enable`/`done` handshake as the forward block, and sits between the loss/next-layer gradient source and the preceding layer's weight-update logic.

## Interface
- `WIDTH`, 128: number of vector elements.
- `DATA_WIDTH`, 16: bits per element, signed two's complement.
- `FRAC_BITS`, 8: fractional bits; ONE = 1 << FRAC_BITS (0x0100 at defaults).

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `enable`  in  1  level-sensitive start/hold request.
- `act_vector`  in  WIDTH*DATA_WIDTH  flattened forward sigmoid outputs `y`; element i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `grad_vector`  in  WIDTH*DATA_WIDTH  flattened upstream gradient `g`; same packing.
- `output_vector`  out  WIDTH*DATA_WIDTH  flattened input gradient; same packing; registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE to RUN: on an edge where `enable`=1. On that edge, `idx` is set to 0 and both pipeline valid bits are cleared.
- RUN: each cycle issues element `idx` and increments `idx`, for issues 0..WIDTH-1. The FSM moves to DONE on the edge that writes element WIDTH-1.
- DONE: `done` is held high while `enable` is 1. An edge with `enable`=0 returns the FSM to IDLE.
- RUN with `enable`=0 on any edge aborts:
  - FSM returns to IDLE and the pipeline is flushed.
  - `done` is never asserted.
  - Elements already written keep their new values; the rest keep their old values.
- `act_vector` and `grad_vector` must be held stable from the start edge until `done`. They are read by index and not captured.
- Stage 1, registered:
  - yc = clamp(y, 0, ONE) as a signed compare. Negative values become 0; values above ONE become ONE.
  - d = (yc * (ONE - yc)) >>> FRAC_BITS, so 0 <= d <= ONE/4.
  - `g` and the element index are registered alongside d.
- Stage 2, registered:
  - p = (g * d) as a signed 2*DATA_WIDTH product.
  - out = p >>> FRAC_BITS, an arithmetic shift (floor toward -inf), truncated to DATA_WIDTH.
  - Because |d| <= 0.25, no overflow is possible and no saturation logic is needed.
- All `>>>` shifts are arithmetic on signed operands. There is no rounding.

## Timing
- Reset values: `output_vector` = all zero, `busy`=0, `done`=0, FSM=IDLE, `idx`=0.
- Assertion of `reset` at any time, including mid-RUN, takes effect immediately (asynchronously) and produces the reset values above.
- Start edge is E0, meaning `enable` is sampled high in IDLE.
  - `busy` rises after E0.
  - Element i is issued at edge E(i+1), lands in stage 1 at E(i+1), and is written to `output_vector` at E(i+2).
- Element WIDTH-1 is written at E(WIDTH+1). On that same edge `busy` falls and `done` rises.
- Total latency from start edge to `done` high is WIDTH+1 edges (129 at defaults).
- Throughput is one element per cycle. There are no bubbles.
- If `enable` is still high when `done` is high and the block then returns to IDLE by dropping `enable`, a new start requires `enable` to be seen high again in IDLE. There is a minimum of one IDLE cycle between runs.
- `enable` dropping on the same edge as the last write: the write completes, and the FSM goes to IDLE with `done` never seen high.

## Test plan
- Center point: y=0x0080, g=0x0100 for all elements, then enable -> every output = 0x0040; `done` rises exactly WIDTH+1 edges after start.
- Negative gradient: y=0x00C0, g=0xFE00 -> d=0x0030, output = 0xFFA0 (-0.375).
- Clamping and endpoints: y ∈ {0x0000, 0x0100, 0x0180, 0xFF00} with g=0x0100 -> all outputs 0x0000.
- Floor and extremes:
  - y=0x0080, g=0xFFFF -> 0xFFFF.
  - y=0x0080, g=0x7FFF -> 0x1FFF.
  - y=0x0001, g=0x7FFF -> 0x0000 (because d=0).
- Abort and reset:
  - Drop `enable` at RUN cycle 10 -> FSM returns to IDLE, `done` never rises, elements 0..7 are updated and the rest are unchanged.
  - Assert `reset` mid-RUN -> all outputs 0, `busy`/`done` 0 immediately, without waiting for a clock edge.
- Back-to-back runs: complete one run, deassert `enable` for 1 cycle, restart with different vectors -> the second result replaces the first completely and latency is identical.
